// File: rtl/iir_output_quantizer_pkg.sv
// Shared fixed-point format constants and status helpers for the IIR output/status blocks.
package iir_output_quantizer_pkg;

  localparam int unsigned WII_DEF  = 8;
  localparam int unsigned WFI_DEF  = 18;
  localparam int unsigned WIQ_DEF  = 3;
  localparam int unsigned WFQ_DEF  = 7;
  localparam int unsigned CNTW_DEF = 8;
  localparam int unsigned CNT_MAXW = 32;

  // Increment that sticks at max_val; counters narrower than CNT_MAXW are zero-extended by the caller.
  function automatic logic [CNT_MAXW-1:0] sat_inc(input logic [CNT_MAXW-1:0] val,
                                                  input logic [CNT_MAXW-1:0] max_val);
    sat_inc = (val == max_val) ? val : val + CNT_MAXW'(1);
  endfunction

endpackage

// File: rtl/iir_sample_fifo.sv
// Synchronous show-ahead FIFO; head is presented on rd_data_o while non-empty, zero otherwise.
module iir_sample_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 10
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] rd_data_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          wr_en, rd_en;

  assign empty_o   = (wr_q == rd_q);
  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign wr_en     = push_i & (~full_o | pop_i);
  assign rd_en     = pop_i & ~empty_o;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + PW'(wr_en);
    rd_d = rd_q + PW'(rd_en);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/iir_output_quantizer.sv
// Round/saturate stage behind the SOS IIR filter: captures on CE, quantizes to the narrow
// sample format, buffers in a show-ahead FIFO and keeps saturation/drop status.
module iir_output_quantizer
  import iir_output_quantizer_pkg::*;
#(
  parameter int unsigned WII   = WII_DEF,
  parameter int unsigned WFI   = WFI_DEF,
  parameter int unsigned WIQ   = WIQ_DEF,
  parameter int unsigned WFQ   = WFQ_DEF,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = CNTW_DEF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CE,
  input  logic [WII+WFI-1:0]   Y_IN,
  input  logic                 OVF_IN,
  output logic [WIQ+WFQ-1:0]   DOUT,
  output logic                 DOUT_VALID,
  input  logic                 DOUT_READY,
  output logic                 SAT_STICKY,
  output logic                 DROP_STICKY,
  output logic [CNTW-1:0]      SAT_CNT,
  output logic [CNTW-1:0]      DROP_CNT,
  input  logic                 CLR_STATUS
);

  localparam int unsigned WY = WII + WFI;
  localparam int unsigned WQ = WIQ + WFQ;
  localparam int unsigned SH = WFI - WFQ;
  localparam int unsigned RW = WY + 1 - SH;

  localparam logic signed [WY:0]   RND_HALF = (WY+1)'(2 ** (SH - 1));
  localparam logic signed [RW-1:0] QMAX_R   = RW'((2 ** (WQ - 1)) - 1);
  localparam logic signed [RW-1:0] QMIN_R   = ~QMAX_R;
  localparam logic [WQ-1:0]        QMAX_Q   = {1'b0, {(WQ-1){1'b1}}};
  localparam logic [WQ-1:0]        QMIN_Q   = {1'b1, {(WQ-1){1'b0}}};
  localparam logic [CNTW-1:0]      CNT_MAX  = '1;

  logic [WY-1:0]        s0_y_q;
  logic                 s0_ovf_q, s0_vld_q;
  logic signed [RW-1:0] s1_rnd_q, s1_rnd_d;
  logic                 s1_ovf_q, s1_vld_q;
  logic [WQ-1:0]        s2_dat_q, s2_dat_d;
  logic                 s2_sat_q, s2_sat_d, s2_vld_q;

  logic                 sat_sticky_q, sat_sticky_d;
  logic                 drop_sticky_q, drop_sticky_d;
  logic [CNTW-1:0]      sat_cnt_q, sat_cnt_d;
  logic [CNTW-1:0]      drop_cnt_q, drop_cnt_d;

  logic signed [WY:0]   rnd_sum;
  logic                 clamp_hi, clamp_lo;
  logic                 fifo_full, fifo_empty, pop, drop;

  // Round half up: add half an output LSB, then floor via arithmetic shift.
  always_comb begin
    rnd_sum  = $signed({s0_y_q[WY-1], s0_y_q}) + RND_HALF;
    s1_rnd_d = RW'(rnd_sum >>> SH);
    clamp_hi = (s1_rnd_q > QMAX_R);
    clamp_lo = (s1_rnd_q < QMIN_R);
    s2_dat_d = clamp_hi ? QMAX_Q : (clamp_lo ? QMIN_Q : s1_rnd_q[WQ-1:0]);
    s2_sat_d = clamp_hi | clamp_lo | s1_ovf_q;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      s0_vld_q <= 1'b0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s0_y_q   <= '0;
      s0_ovf_q <= 1'b0;
      s1_rnd_q <= '0;
      s1_ovf_q <= 1'b0;
      s2_dat_q <= '0;
      s2_sat_q <= 1'b0;
    end else begin
      s0_vld_q <= CE;
      if (CE) begin
        s0_y_q   <= Y_IN;
        s0_ovf_q <= OVF_IN;
      end
      s1_vld_q <= s0_vld_q;
      s1_rnd_q <= s1_rnd_d;
      s1_ovf_q <= s0_ovf_q;
      s2_vld_q <= s1_vld_q;
      s2_dat_q <= s2_dat_d;
      s2_sat_q <= s2_sat_d;
    end
  end

  iir_sample_fifo #(
    .DEPTH (DEPTH),
    .W     (WQ)
  ) u_fifo (
    .CLK         (CLK),
    .RESET       (RESET),
    .push_i      (s2_vld_q),
    .push_data_i (s2_dat_q),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .rd_data_o   (DOUT)
  );

  assign DOUT_VALID = ~fifo_empty;
  assign pop        = DOUT_VALID & DOUT_READY;
  // A pop in the same cycle frees the slot, so only an unrelieved full FIFO drops.
  assign drop       = s2_vld_q & fifo_full & ~pop;

  always_comb begin
    sat_sticky_d  = sat_sticky_q;
    drop_sticky_d = drop_sticky_q;
    sat_cnt_d     = sat_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    if (CLR_STATUS) begin
      sat_sticky_d  = 1'b0;
      drop_sticky_d = 1'b0;
      sat_cnt_d     = '0;
      drop_cnt_d    = '0;
    end else begin
      if (s2_vld_q && s2_sat_q) begin
        sat_sticky_d = 1'b1;
        sat_cnt_d    = CNTW'(sat_inc(CNT_MAXW'(sat_cnt_q), CNT_MAXW'(CNT_MAX)));
      end
      if (drop) begin
        drop_sticky_d = 1'b1;
        drop_cnt_d    = CNTW'(sat_inc(CNT_MAXW'(drop_cnt_q), CNT_MAXW'(CNT_MAX)));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sat_sticky_q  <= 1'b0;
      drop_sticky_q <= 1'b0;
      sat_cnt_q     <= '0;
      drop_cnt_q    <= '0;
    end else begin
      sat_sticky_q  <= sat_sticky_d;
      drop_sticky_q <= drop_sticky_d;
      sat_cnt_q     <= sat_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign SAT_STICKY  = sat_sticky_q;
  assign DROP_STICKY = drop_sticky_q;
  assign SAT_CNT     = sat_cnt_q;
  assign DROP_CNT    = drop_cnt_q;

endmodule

// File: tb/tb_iir_output_quantizer.sv
// Scoreboard bench for iir_output_quantizer: arithmetic reference model feeds an expected
// queue, a negedge monitor compares DUT outputs and status against it.
module tb_iir_output_quantizer;

  localparam int WII   = 8;
  localparam int WFI   = 18;
  localparam int WIQ   = 3;
  localparam int WFQ   = 7;
  localparam int DEPTH = 4;
  localparam int CNTW  = 8;
  localparam int WY    = WII + WFI;
  localparam int WQ    = WIQ + WFQ;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic            CLK = 1'b0;
  logic            RESET = 1'b0;
  logic            CE = 1'b0;
  logic [WY-1:0]   Y_IN = '0;
  logic            OVF_IN = 1'b0;
  logic [WQ-1:0]   DOUT;
  logic            DOUT_VALID;
  logic            DOUT_READY = 1'b0;
  logic            SAT_STICKY, DROP_STICKY;
  logic [CNTW-1:0] SAT_CNT, DROP_CNT;
  logic            CLR_STATUS = 1'b0;

  always #5 CLK = ~CLK;

  iir_output_quantizer #(
    .WII(WII), .WFI(WFI), .WIQ(WIQ), .WFQ(WFQ), .DEPTH(DEPTH), .CNTW(CNTW)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .CE         (CE),
    .Y_IN       (Y_IN),
    .OVF_IN     (OVF_IN),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY),
    .SAT_STICKY (SAT_STICKY),
    .DROP_STICKY(DROP_STICKY),
    .SAT_CNT    (SAT_CNT),
    .DROP_CNT   (DROP_CNT),
    .CLR_STATUS (CLR_STATUS)
  );

  typedef struct {
    bit            v;
    logic [WQ-1:0] q;
    bit            sat;
  } smp_t;

  smp_t          dl[$];
  logic [WQ-1:0] mq[$];
  int            exp_sat_cnt, exp_drop_cnt;
  bit            exp_sat_st, exp_drop_st;
  bit            started = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;

  // Value-level reference: real-valued round half up, then clamp to the output range.
  function automatic void ref_quant(input logic [WY-1:0] y, output logic [WQ-1:0] q,
                                    output bit clamp);
    longint num, den, fl, lim;
    den = longint'(1) << (WFI - WFQ);
    num = longint'($signed(y)) + den / 2;
    fl  = num / den;
    if (num < 0 && (num % den) != 0) fl = fl - 1;
    lim   = longint'(1) << (WQ - 1);
    clamp = 1'b0;
    if (fl > lim - 1) begin
      fl = lim - 1; clamp = 1'b1;
    end else if (fl < -lim) begin
      fl = -lim; clamp = 1'b1;
    end
    q = WQ'(fl);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Cycle model: three-sample delay to the FIFO, bounded queue of DEPTH, status counters.
  initial begin
    smp_t a, cap;
    bit   drop, clamp;
    forever begin
      @(posedge CLK);
      if (RESET === 1'b0) begin
        dl.delete();
        mq.delete();
        for (int i = 0; i < 3; i++) dl.push_back('{v: 1'b0, q: '0, sat: 1'b0});
        exp_sat_cnt = 0; exp_drop_cnt = 0; exp_sat_st = 0; exp_drop_st = 0;
        started = 1'b1;
      end else if (started) begin
        a = dl.pop_front();
        if (mq.size() > 0 && DOUT_READY) void'(mq.pop_front());
        drop = a.v && (mq.size() >= DEPTH);
        if (a.v && !drop) mq.push_back(a.q);
        if (CLR_STATUS) begin
          exp_sat_cnt = 0; exp_drop_cnt = 0; exp_sat_st = 0; exp_drop_st = 0;
        end else begin
          if (a.v && a.sat) begin
            exp_sat_st = 1;
            if (exp_sat_cnt < CMAX) exp_sat_cnt++;
          end
          if (drop) begin
            exp_drop_st = 1;
            if (exp_drop_cnt < CMAX) exp_drop_cnt++;
          end
        end
        ref_quant(Y_IN, cap.q, clamp);
        cap.v   = CE;
        cap.sat = clamp | OVF_IN;
        dl.push_back(cap);
      end
    end
  end

  // Monitor: compare presented head and status against the model on every falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (started) begin
        check("dout_valid", 32'(DOUT_VALID), 32'(mq.size() != 0));
        check("dout", 32'(DOUT), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        check("sat_sticky", 32'(SAT_STICKY), 32'(exp_sat_st));
        check("drop_sticky", 32'(DROP_STICKY), 32'(exp_drop_st));
        check("sat_cnt", 32'(SAT_CNT), 32'(exp_sat_cnt));
        check("drop_cnt", 32'(DROP_CNT), 32'(exp_drop_cnt));
      end
    end
  end

  task automatic drive(input bit ce, input logic [WY-1:0] y, input bit ovf, input bit rdy,
                       input bit rst_n, input bit clr);
    @(posedge CLK);
    #2;
    CE = ce; Y_IN = y; OVF_IN = ovf; DOUT_READY = rdy; RESET = rst_n; CLR_STATUS = clr;
  endtask

  task automatic one_sample(input logic [WY-1:0] y, input bit ovf);
    drive(1'b1, y, ovf, 1'b1, 1'b1, 1'b0);
    repeat (4) drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  logic [WY-1:0] dir_y [9] = '{26'h0060000, 26'h0000400, 26'h00003FF, 26'h3FFFC00,
                               26'h3FFFBFF, 26'h0100000, 26'h3EC0000, 26'h00FFC00,
                               26'h0040000};

  initial begin
    int mode, base;
    logic [WY-1:0] y;
    repeat (3) drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Directed rounding, saturation and overflow samples, one at a time.
    for (int i = 0; i < 9; i++) one_sample(dir_y[i], i == 8);

    // Six samples into a stalled FIFO: four kept, two dropped, then drained.
    for (int i = 0; i < 6; i++) drive(1'b1, WY'($urandom_range(0, 'h7FFFF)), 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Fill, then stream with simultaneous pop/push while full, then reset mid-stream.
    for (int i = 0; i < 4; i++) drive(1'b1, WY'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) drive(1'b1, WY'($urandom), 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, WY'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) drive(1'b1, WY'($urandom), 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (6) drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Long stall to saturate both counters, then clear during live increments.
    repeat (300) drive(1'b1, WY'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b0);
    drive(1'b1, 26'h0100000, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (3) drive(1'b1, 26'h0100000, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 26'h0100000, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (8) drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Randomized traffic with mixed value ranges, back-pressure, clears and resets.
    for (int i = 0; i < 3000; i++) begin
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: y = WY'($urandom);
        1: y = WY'(int'($urandom_range(0, 8191)) - 4096);
        2: y = WY'(32'h00FFC00 + $urandom_range(0, 2048) - 1024);
        default: begin
          base = -(1 << 20);
          y = WY'(base + int'($urandom_range(0, 2048)) - 1024);
        end
      endcase
      drive(($urandom_range(0, 3) != 0), y, ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 699) != 0),
            ($urandom_range(0, 99) == 0));
    end
    repeat (10) drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
